metric_sequencer: RTL
=====================

# metric_sequencer

Sequencing controller for the Viterbi add-compare-select (ACS) stage. It accepts one received symbol per handshake and then walks the 64 ACS iterations. For each iteration it drives the metric memory's read/write addresses, `Active` and ping-pong bank select. It also generates write-side addressing and strobes for the 2048×8 survivor RAM. It sits between the branch-metric front end (symbol source) and the METRICMEMORY / survivor RAM pair.

## Interface
Parameters (values come from `params.v`; not overridden per instance):
- `N_ITER`, 64, ACS iterations per symbol (256 states / 4 ACS units).
- `WD_FSM`, 6, iteration-counter width, log2(`N_ITER`).
- `WD_RAM_ADDRESS`, 11, survivor RAM address width.

Ports:
- `Clock1`  in  1  single system clock; all state updates on rising edge.
- `Reset`  in  1  **one clock; reset is synchronous and active-high**.
- `FrameStart`  in  1  pulse; clears symbol count and bank select; sampled in IDLE only.
- `SymbolValid`  in  1  upstream has a symbol's branch metrics ready.
- `SymbolReady`  out  1  controller can accept a symbol.
- `Active`  out  1  metric-memory write enable; high for each RUN iteration.
- `MMWriteAddress`  out  `WD_FSM`  metric word being written (4 states).
- `MMReadAddress`  out  `WD_FSM`-1  metric word pair being read.
- `MMBlockSelect`  out  1  ping-pong bank: writes go to bank A when 0, reads come from the other bank.
- `SurvEnable_n`  out  1  survivor RAM enable, active low.
- `SurvRWSelect`  out  1  survivor RAM direction: 0 = write, 1 = read.
- `SurvAddress`  out  `WD_RAM_ADDRESS`  survivor RAM address.
- `SymbolDone`  out  1  one-cycle pulse after the last iteration.
- `SymbolCount`  out  6  index of the current symbol within the 64-symbol survivor window.

## Operation
- FSM with three states: IDLE, RUN, DONE.
  - IDLE: `SymbolReady` = 1. `SymbolValid` & `SymbolReady` moves to RUN with `iter` = 0.
  - RUN: `iter` increments each cycle. At `iter` = 63 the next state is DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- RUN outputs for the current `iter`:
  - `Active` = 1.
  - `MMWriteAddress` = `iter`.
  - `MMReadAddress` = `iter[4:0]`. New states 4i..4i+3 depend on old states 8i..8i+7 mod 256, i.e. words 2i and 2i+1 mod 64.
- Survivor writes happen in RUN only:
  - `SurvRWSelect` = 0 throughout RUN.
  - `SurvEnable_n` = 0 on odd `iter` only, because 4 decision bits per iteration make one byte every 2 iterations.
  - `SurvAddress` = {`SymbolCount`, `iter[5:1]`}, giving 32 bytes per symbol.
- DONE:
  - `SymbolDone` = 1.
  - `MMBlockSelect` toggles, so the next symbol reads the bank just written.
  - `SymbolCount` increments modulo 64; 63 wraps to 0, and the survivor address wraps to 0.
- Outside RUN: `Active` = 0, `SurvEnable_n` = 1, `SurvRWSelect` = 1. Addresses hold their last values.
- `FrameStart` in IDLE sets `SymbolCount` = 0 and `MMBlockSelect` = 0.
  - If `SymbolValid` is asserted in the same cycle, the symbol is accepted and runs with count 0 and bank 0.
  - `FrameStart` in RUN or DONE is ignored.
- `SymbolValid` during RUN or DONE is not accepted. Upstream holds it until `SymbolReady` is high. Each handshake produces exactly one symbol.

## Timing
- All outputs are registered; each output reflects the state entered on the preceding rising edge.
- Reset values: state IDLE, `iter` 0, `SymbolReady` 1, `Active` 0, `MMWriteAddress` 0, `MMReadAddress` 0, `MMBlockSelect` 0, `SurvEnable_n` 1, `SurvRWSelect` 1, `SurvAddress` 0, `SymbolDone` 0, `SymbolCount` 0.
- While `Reset` is high, handshakes and `FrameStart` are ignored.
- Handshake accepted at edge t:
  - `Active` is high for cycles t+1 … t+64.
  - `SymbolDone` is high in cycle t+65.
  - `SymbolReady` is high again in cycle t+66.
  - Throughput is 66 cycles per symbol.
- Reset asserted mid-RUN: after the next edge, every output holds its reset value. The partial symbol is discarded and no `SymbolDone` is issued.
- Metric memory writes on the negedge of `Clock1`. Addresses and `Active` are stable from rising edge to rising edge, which meets its setup requirement.

## Structure
- Shared in `params.v`: `N_ITER`, `WD_FSM`, `WD_RAM_ADDRESS`, and the state encodings (`S_IDLE` = 0, `S_RUN` = 1, `S_DONE` = 2).
- One sub-module, `mm_iter_counter`: a 6-bit counter with synchronous clear and enable, plus a terminal-count flag at 63. The FSM and output registers stay in `metric_sequencer`.

## Test plan
- Reset, then `SymbolValid` at cycle 0:
  - `Active` is high for 64 cycles.
  - `MMWriteAddress` runs 0..63; `MMReadAddress` runs 0..31 twice.
  - `SymbolDone` pulses at cycle 65 and `MMBlockSelect` reads 1 afterwards.
  - `SymbolReady` returns at cycle 66.
- Survivor write check:
  - Symbol 0 gives 32 strobes (`SurvEnable_n` = 0) at addresses 0..31, with `SurvRWSelect` = 0.
  - The 6th symbol (`SymbolCount` = 5) gives addresses 160..191.
- 64 back-to-back symbols: `SymbolCount` wraps 63 → 0, `SurvAddress` restarts at 0, and `MMBlockSelect` ends at 0.
- `SymbolValid` held high continuously: exactly one symbol is accepted per 66 cycles, and no acceptance occurs while in RUN or DONE.
- `Reset` pulsed at `iter` = 30: on the next cycle `Active` = 0, every output holds its reset value, and no `SymbolDone` appears.
- After 3 symbols, `FrameStart` and `SymbolValid` together in IDLE: the symbol runs with `SymbolCount` 0, `MMBlockSelect` 0 and `SurvAddress` starting at 0. A `FrameStart` pulse during RUN has no effect.

Source files
------------

// File: rtl/metric_sequencer_pkg.sv
// Shared widths, FSM encoding and output-register bundle for the ACS
// metric sequencer.
package metric_sequencer_pkg;

  localparam int unsigned N_ITER         = 64;
  localparam int unsigned WD_FSM         = 6;
  localparam int unsigned WD_RAM_ADDRESS = 11;
  localparam int unsigned WD_SYMCNT      = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Every registered output of the sequencer, held in one register bank
  typedef struct packed {
    logic                      ready;
    logic                      active;
    logic [WD_FSM-1:0]         wr_addr;
    logic [WD_FSM-2:0]         rd_addr;
    logic                      bank;
    logic                      surv_en_n;
    logic                      surv_rw;
    logic [WD_RAM_ADDRESS-1:0] surv_addr;
    logic                      done;
    logic [WD_SYMCNT-1:0]      sym_cnt;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{
    ready:     1'b1,
    active:    1'b0,
    wr_addr:   '0,
    rd_addr:   '0,
    bank:      1'b0,
    surv_en_n: 1'b1,
    surv_rw:   1'b1,
    surv_addr: '0,
    done:      1'b0,
    sym_cnt:   '0
  };

endpackage

// File: rtl/metric_sequencer_if.sv
// Symbol handshake plus metric-memory and survivor-RAM control bundle.
interface metric_sequencer_if;
  import metric_sequencer_pkg::*;

  logic                      FrameStart;
  logic                      SymbolValid;
  logic                      SymbolReady;
  logic                      Active;
  logic [WD_FSM-1:0]         MMWriteAddress;
  logic [WD_FSM-2:0]         MMReadAddress;
  logic                      MMBlockSelect;
  logic                      SurvEnable_n;
  logic                      SurvRWSelect;
  logic [WD_RAM_ADDRESS-1:0] SurvAddress;
  logic                      SymbolDone;
  logic [WD_SYMCNT-1:0]      SymbolCount;

  modport master (
    input  FrameStart, SymbolValid,
    output SymbolReady, Active, MMWriteAddress, MMReadAddress, MMBlockSelect,
           SurvEnable_n, SurvRWSelect, SurvAddress, SymbolDone, SymbolCount
  );

  modport slave (
    output FrameStart, SymbolValid,
    input  SymbolReady, Active, MMWriteAddress, MMReadAddress, MMBlockSelect,
           SurvEnable_n, SurvRWSelect, SurvAddress, SymbolDone, SymbolCount
  );

endinterface

// File: rtl/metric_sequencer_mm_iter_counter.sv
// ACS iteration counter: synchronous clear/enable, registered flag at the
// last iteration.
module mm_iter_counter
  import metric_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [WD_FSM-1:0] count_o,
  output logic              tc_o
);

  logic [WD_FSM-1:0] count_q, count_d;
  logic              tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
    // Flag is computed from the next value so it lines up with count_q
    tc_d = (count_d == WD_FSM'(N_ITER - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: rtl/metric_sequencer.sv
// Viterbi ACS sequencer: one symbol per handshake, 64 iterations of metric
// memory and survivor RAM addressing, then a one-cycle done/bank swap.
module metric_sequencer
  import metric_sequencer_pkg::*;
(
  input  logic               Clock1,
  input  logic               Reset,
  metric_sequencer_if.master bus
);

  state_e            state_q, state_d;
  seq_out_t          out_q, out_d;
  logic [WD_FSM-1:0] iter_q;
  logic              iter_tc;
  logic [WD_FSM-1:0] iter_nxt;
  logic              accept;

  mm_iter_counter u_iter (
    .clk_i   (Clock1),
    .rst_i   (Reset),
    .clr_i   (accept),
    .en_i    (state_q == S_RUN),
    .count_o (iter_q),
    .tc_o    (iter_tc)
  );

  always_ff @(posedge Clock1) begin
    if (Reset) begin
      state_q <= S_IDLE;
      out_q   <= SEQ_OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    out_d            = out_q;
    out_d.ready      = 1'b0;
    out_d.active     = 1'b0;
    out_d.surv_en_n  = 1'b1;
    out_d.surv_rw    = 1'b1;
    out_d.done       = 1'b0;
    accept           = 1'b0;
    iter_nxt         = iter_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.FrameStart) begin
          out_d.sym_cnt = '0;
          out_d.bank    = 1'b0;
        end
        if (bus.SymbolValid) begin
          accept   = 1'b1;
          iter_nxt = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (iter_tc) begin
          state_d       = S_DONE;
          out_d.sym_cnt = out_q.sym_cnt + 1'b1;
          out_d.bank    = ~out_q.bank;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs describe the state being entered so they are registered
    unique case (state_d)
      S_IDLE: out_d.ready = 1'b1;
      S_RUN: begin
        out_d.active    = 1'b1;
        out_d.wr_addr   = iter_nxt;
        out_d.rd_addr   = iter_nxt[WD_FSM-2:0];
        out_d.surv_rw   = 1'b0;
        out_d.surv_en_n = ~iter_nxt[0];
        out_d.surv_addr = {out_d.sym_cnt, iter_nxt[WD_FSM-1:1]};
      end
      S_DONE:  out_d.done = 1'b1;
      default: out_d.ready = 1'b0;
    endcase
  end

  assign bus.SymbolReady    = out_q.ready;
  assign bus.Active         = out_q.active;
  assign bus.MMWriteAddress = out_q.wr_addr;
  assign bus.MMReadAddress  = out_q.rd_addr;
  assign bus.MMBlockSelect  = out_q.bank;
  assign bus.SurvEnable_n   = out_q.surv_en_n;
  assign bus.SurvRWSelect   = out_q.surv_rw;
  assign bus.SurvAddress    = out_q.surv_addr;
  assign bus.SymbolDone     = out_q.done;
  assign bus.SymbolCount    = out_q.sym_cnt;

endmodule
